axi_lite_responder: RTL
=======================

# axi_lite_responder

Single-beat AXI responder: the slave end of the one-beat read/write traffic issued by the core's AXI master port. It accepts AR, AW and W handshakes, performs one access at a time on a simple request/grant memory-side port, and returns R or B responses. It sits between an AXI interconnect and a local memory or register block, such as a scratchpad or peripheral CSR bank.

## Interface
- ADDR_W, 32, address width of AXI and memory-side port
- DATA_W, 32, data width; strobe width is DATA_W/8
- BASE_ADDR, 32'h6000_0000, first decoded byte address
- SIZE_BYTES, 32'h0001_0000, decoded window size; accesses outside it get SLVERR

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset (asserted at 0)
- s_araddr in ADDR_W; s_arvalid in 1; s_arready out 1
- s_rdata out DATA_W; s_rresp out 2; s_rlast out 1; s_rvalid out 1; s_rready in 1
- s_awaddr in ADDR_W; s_awvalid in 1; s_awready out 1
- s_wdata in DATA_W; s_wstrb in DATA_W/8; s_wvalid in 1; s_wready out 1
- s_bresp out 2; s_bvalid out 1; s_bready in 1
- mem_req out 1: access request, held until granted
- mem_we out 1: 1 write, 0 read
- mem_addr out ADDR_W; mem_be out DATA_W/8; mem_wdata out DATA_W
- mem_gnt in 1: request accepted in the cycle mem_req & mem_gnt
- mem_rvalid in 1; mem_rdata in DATA_W: read data, at least 1 cycle after grant

The len, size and burst fields are not used. Every transfer is one beat, and s_rlast = s_rvalid.

## Operation
- States: IDLE, RD_REQ, RD_WAIT, R_RESP, WR_REQ, B_RESP. One transaction is in flight at a time.
- IDLE ready generation (combinational, may depend on valid):
  - s_awready = IDLE & !aw_held
  - s_wready = IDLE & !w_held
  - s_arready = IDLE & !aw_held & !w_held
- AW and W are captured independently into holding registers and set aw_held / w_held.
- Tie-break when arvalid and (awvalid | wvalid) are both high in IDLE with nothing held:
  - last_was_read = 0: read wins, and awready = wready = 0 that cycle.
  - last_was_read = 1: write channels win, and arready = 0.
- AR accepted:
  - Latch the address. In range: go to RD_REQ. Out of range: go to R_RESP with rresp = 2'b10 and rdata = 0, with no memory access.
  - Set last_was_read = 1.
- RD_REQ: mem_req = 1, mem_we = 0 until mem_gnt, then RD_WAIT.
- RD_WAIT: on mem_rvalid, register mem_rdata into s_rdata, set rresp = 2'b00, go to R_RESP.
- R_RESP: s_rvalid = 1 until s_rready, then IDLE.
- When aw_held & w_held are both set (including the cycle after the last of them is captured):
  - Out of range: B_RESP with bresp = 2'b10.
  - wstrb == 0: B_RESP with bresp = 2'b00 and no memory access.
  - Otherwise: WR_REQ.
  - Set last_was_read = 0.
- WR_REQ: mem_req = 1, mem_we = 1, mem_be = wstrb until mem_gnt, then B_RESP.
- B_RESP: s_bvalid = 1 until s_bready, then clear both held flags and go to IDLE.
- Range check: BASE_ADDR <= addr < BASE_ADDR + SIZE_BYTES, evaluated at ADDR_W+1 bits so the sum cannot wrap.
- mem_addr, mem_be and mem_wdata are driven from the holding registers and stay stable while mem_req is high.
- A partially captured write blocks AR until the write completes, so a held AW or W is never starved.

## Timing
- Reset (rst = 0, asynchronous):
  - State = IDLE; aw_held = w_held = 0; last_was_read = 0.
  - s_rvalid = s_bvalid = mem_req = 0; s_rdata = 0; s_rresp = s_bresp = 0.
  - An in-flight transaction is dropped with no response. Release is synchronous to clk.
- Read latency with mem_gnt immediate and mem_rvalid one cycle after grant:
  - AR handshake at cycle 0; mem_req at cycle 1; mem_rvalid at cycle 2; s_rvalid at cycle 3.
- Write latency with AW and W together at cycle 0 and immediate grant:
  - mem_req at cycle 1; s_bvalid at cycle 2.
- Error or zero-strobe responses appear one cycle after the completing handshake.
- All ready signals are low outside IDLE. Back-to-back transactions need at least one IDLE cycle between response handshake and next address acceptance.
- mem_rvalid outside RD_WAIT is ignored.

## Test plan
- Read 0x6000_0010 with mem_gnt immediate and mem_rdata = 0xDEADBEEF one cycle later -> s_rvalid at cycle 3, rdata = 0xDEADBEEF, rresp = 0, rlast = 1.
- W (wdata = 0x1234_5678, wstrb = 4'b0011) 2 cycles before AW 0x6000_0004 -> exactly one mem_req with we = 1, be = 0011, addr = 0x6000_0004; then bvalid, bresp = 0. AR presented meanwhile is not accepted until after B.
- AR and AW+W valid together after reset -> read served first. On the next tie the write wins; alternation continues.
- Read 0x5FFF_FFFC and write 0x6001_0000 -> rresp = 2'b10 with rdata = 0, bresp = 2'b10, no mem_req ever.
- Write with wstrb = 0 -> bresp = 0, no mem_req. Hold rready/bready low 5 cycles -> valid and payload stable throughout.
- Assert rst in RD_WAIT -> all valids drop immediately; after release, a fresh read completes normally and the late mem_rvalid is ignored.

Source files
------------

// File: rtl/axi_lite_responder_if.sv
// AXI-Lite single-beat channel bundle between an interconnect master and the responder.
interface axi_lite_responder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   s_araddr;
  logic                s_arvalid;
  logic                s_arready;
  logic [DATA_W-1:0]   s_rdata;
  logic [1:0]          s_rresp;
  logic                s_rlast;
  logic                s_rvalid;
  logic                s_rready;
  logic [ADDR_W-1:0]   s_awaddr;
  logic                s_awvalid;
  logic                s_awready;
  logic [DATA_W-1:0]   s_wdata;
  logic [DATA_W/8-1:0] s_wstrb;
  logic                s_wvalid;
  logic                s_wready;
  logic [1:0]          s_bresp;
  logic                s_bvalid;
  logic                s_bready;

  modport slave (
    input  s_araddr, s_arvalid, s_rready,
    input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
    output s_arready, s_rdata, s_rresp, s_rlast, s_rvalid,
    output s_awready, s_wready, s_bresp, s_bvalid
  );

  modport master (
    output s_araddr, s_arvalid, s_rready,
    output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
    input  s_arready, s_rdata, s_rresp, s_rlast, s_rvalid,
    input  s_awready, s_wready, s_bresp, s_bvalid
  );
endinterface

// File: rtl/axi_lite_responder.sv
// Single-beat AXI-Lite slave: serialises AR / AW+W onto a request/grant memory port, one access in flight.
module axi_lite_responder #(
  parameter int              ADDR_W     = 32,
  parameter int              DATA_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h6000_0000,
  parameter logic [ADDR_W-1:0] SIZE_BYTES = 32'h0001_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  axi_lite_responder_if.slave   s,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W/8-1:0]   mem_be,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_W-1:0]     mem_rdata
);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    R_RESP  = 3'd3,
    WR_REQ  = 3'd4,
    B_RESP  = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic                aw_held_q, aw_held_d;
  logic                w_held_q, w_held_d;
  logic                last_was_read_q, last_was_read_d;
  logic                rvalid_q, rvalid_d;
  logic                bvalid_q, bvalid_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          rresp_q, rresp_d;
  logic [1:0]          bresp_q, bresp_d;
  logic [ADDR_W-1:0]   araddr_q, araddr_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;

  logic                idle;
  logic                nothing_held;
  logic                tie;
  logic                ar_hs, aw_hs, w_hs;
  logic                aw_have, w_have;
  logic [ADDR_W-1:0]   wr_addr;
  logic [STRB_W-1:0]   wr_strb;

  // Sum is formed one bit wider so a window ending at the top of the address space cannot wrap.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    logic [ADDR_W:0] lo;
    logic [ADDR_W:0] hi;
    logic [ADDR_W:0] x;
    lo = {1'b0, BASE_ADDR};
    hi = lo + {1'b0, SIZE_BYTES};
    x  = {1'b0, a};
    return (x >= lo) && (x < hi);
  endfunction

  assign idle         = (state_q == IDLE);
  assign nothing_held = !aw_held_q && !w_held_q;
  assign tie          = s.s_arvalid && (s.s_awvalid || s.s_wvalid) && nothing_held;

  assign s.s_arready = idle && nothing_held && !(tie && last_was_read_q);
  assign s.s_awready = idle && !aw_held_q && !(tie && !last_was_read_q);
  assign s.s_wready  = idle && !w_held_q && !(tie && !last_was_read_q);

  assign ar_hs = s.s_arvalid && s.s_arready;
  assign aw_hs = s.s_awvalid && s.s_awready;
  assign w_hs  = s.s_wvalid && s.s_wready;

  // A write is decided in the cycle its last half is captured, so the incoming values bypass the holding regs.
  assign aw_have = aw_held_q || aw_hs;
  assign w_have  = w_held_q || w_hs;
  assign wr_addr = aw_hs ? s.s_awaddr : awaddr_q;
  assign wr_strb = w_hs ? s.s_wstrb : wstrb_q;

  always_comb begin
    state_d         = state_q;
    aw_held_d       = aw_held_q;
    w_held_d        = w_held_q;
    last_was_read_d = last_was_read_q;
    rdata_d         = rdata_q;
    rresp_d         = rresp_q;
    bresp_d         = bresp_q;
    araddr_d        = araddr_q;
    awaddr_d        = awaddr_q;
    wdata_d         = wdata_q;
    wstrb_d         = wstrb_q;

    if (ar_hs) araddr_d = s.s_araddr;
    if (aw_hs) begin
      awaddr_d  = s.s_awaddr;
      aw_held_d = 1'b1;
    end
    if (w_hs) begin
      wdata_d  = s.s_wdata;
      wstrb_d  = s.s_wstrb;
      w_held_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (ar_hs) begin
          last_was_read_d = 1'b1;
          if (in_range(s.s_araddr)) begin
            state_d = RD_REQ;
          end else begin
            state_d = R_RESP;
            rresp_d = 2'b10;
            rdata_d = '0;
          end
        end else if (aw_have && w_have) begin
          last_was_read_d = 1'b0;
          if (!in_range(wr_addr)) begin
            state_d = B_RESP;
            bresp_d = 2'b10;
          end else if (wr_strb == '0) begin
            state_d = B_RESP;
            bresp_d = 2'b00;
          end else begin
            state_d = WR_REQ;
          end
        end
      end
      RD_REQ: begin
        if (mem_gnt) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (mem_rvalid) begin
          rdata_d = mem_rdata;
          rresp_d = 2'b00;
          state_d = R_RESP;
        end
      end
      R_RESP: begin
        if (s.s_rready) state_d = IDLE;
      end
      WR_REQ: begin
        if (mem_gnt) begin
          bresp_d = 2'b00;
          state_d = B_RESP;
        end
      end
      B_RESP: begin
        if (s.s_bready) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    rvalid_d  = (state_d == R_RESP);
    bvalid_d  = (state_d == B_RESP);
    mem_req_d = (state_d == RD_REQ) || (state_d == WR_REQ);
    mem_we_d  = (state_d == WR_REQ);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      aw_held_q       <= 1'b0;
      w_held_q        <= 1'b0;
      last_was_read_q <= 1'b0;
      rvalid_q        <= 1'b0;
      bvalid_q        <= 1'b0;
      mem_req_q       <= 1'b0;
      mem_we_q        <= 1'b0;
      rdata_q         <= '0;
      rresp_q         <= 2'b00;
      bresp_q         <= 2'b00;
    end else begin
      state_q         <= state_d;
      aw_held_q       <= aw_held_d;
      w_held_q        <= w_held_d;
      last_was_read_q <= last_was_read_d;
      rvalid_q        <= rvalid_d;
      bvalid_q        <= bvalid_d;
      mem_req_q       <= mem_req_d;
      mem_we_q        <= mem_we_d;
      rdata_q         <= rdata_d;
      rresp_q         <= rresp_d;
      bresp_q         <= bresp_d;
    end
  end

  // Holding registers are only meaningful once their held flag is set, so they carry no reset.
  always_ff @(posedge clk) begin
    araddr_q <= araddr_d;
    awaddr_q <= awaddr_d;
    wdata_q  <= wdata_d;
    wstrb_q  <= wstrb_d;
  end

  assign s.s_rvalid = rvalid_q;
  assign s.s_rlast  = rvalid_q;
  assign s.s_rdata  = rdata_q;
  assign s.s_rresp  = rresp_q;
  assign s.s_bvalid = bvalid_q;
  assign s.s_bresp  = bresp_q;

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_we_q ? awaddr_q : araddr_q;
  assign mem_be    = mem_we_q ? wstrb_q : {STRB_W{1'b1}};
  assign mem_wdata = wdata_q;
endmodule
